// File: rtl/multicycle_datapath.sv
// multicycle_datapath: RV64I-subset datapath with its own FETCH/DECODE/EXECUTE/MEM/WB sequencer.
// Define PERF_COUNTERS_EN to add the cycle_count and instret_count outputs.
module multicycle_datapath #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int I_ADDR_BITS      = 6,
    parameter int D_ADDR_BITS      = 6,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        imem_req,
    output logic [I_ADDR_BITS-1:0]      imem_addr,
    input  logic                        imem_ready,
    input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [D_ADDR_BITS-1:0]      dmem_addr,
    output logic [WORDSIZE-1:0]         dmem_wdata,
    input  logic                        dmem_ready,
    input  logic [WORDSIZE-1:0]         dmem_rdata,
    output logic [WORDSIZE-1:0]         pc,
    output logic                        halted,
    output logic                        illegal
`ifdef PERF_COUNTERS_EN
    ,
    output logic [WORDSIZE-1:0]         cycle_count,
    output logic [WORDSIZE-1:0]         instret_count
`endif
);
    localparam int SHW    = $clog2(WORDSIZE);
    localparam int EA_LSB = (WORDSIZE == 64) ? 3 : 2;
    localparam int EA_W   = EA_LSB + D_ADDR_BITS;
    localparam logic [2:0] MEM_F3 = (WORDSIZE == 64) ? 3'b011 : 3'b010;
    localparam logic [WORDSIZE-1:0] FOUR = WORDSIZE'(4);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t state_q, state_d;

    logic [INSTRUCTION_SIZE-1:0] ir;
    logic [WORDSIZE-1:0] rf [32];
    logic [WORDSIZE-1:0] a_q, b_q, imm_q, res_q, pc_q;
    logic [D_ADDR_BITS-1:0] ea_q;
    logic illegal_q;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    logic is_op, is_opimm, is_load, is_store, is_branch, is_jal, is_sys;
    assign is_op     = opcode == 7'b0110011;
    assign is_opimm  = opcode == 7'b0010011;
    assign is_load   = opcode == 7'b0000011;
    assign is_store  = opcode == 7'b0100011;
    assign is_branch = opcode == 7'b1100011;
    assign is_jal    = opcode == 7'b1101111;
    assign is_sys    = opcode == 7'b1110011;

    logic shift_ok, legal;
    assign shift_ok = (ir[31:26] == 6'b000000 ||
                       (ir[31:26] == 6'b010000 && funct3 == 3'b101)) &&
                      (WORDSIZE == 64 || !ir[25]);

    always_comb begin
        legal = 1'b0;
        unique case (1'b1)
            is_op: legal = funct7 == 7'b0000000 ||
                           (funct7 == 7'b0100000 &&
                            (funct3 == 3'b000 || funct3 == 3'b101));
            is_opimm: legal = (funct3 != 3'b001 && funct3 != 3'b101) || shift_ok;
            is_load, is_store: legal = funct3 == MEM_F3;
            is_branch: legal = funct3[2:1] != 2'b01;
            is_jal, is_sys: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    logic [WORDSIZE-1:0] imm_d;
    always_comb begin
        imm_d = {{(WORDSIZE-12){ir[31]}}, ir[31:20]};
        unique case (1'b1)
            is_store:  imm_d = {{(WORDSIZE-12){ir[31]}}, ir[31:25], ir[11:7]};
            is_branch: imm_d = {{(WORDSIZE-13){ir[31]}}, ir[31], ir[7],
                                ir[30:25], ir[11:8], 1'b0};
            is_jal:    imm_d = {{(WORDSIZE-21){ir[31]}}, ir[31], ir[19:12],
                                ir[20], ir[30:21], 1'b0};
            default: ;
        endcase
    end

    // OP uses rs2 as second operand, everything else the latched immediate
    logic [WORDSIZE-1:0] op2, alu;
    logic signed [WORDSIZE-1:0] sra_res;
    logic [SHW-1:0] shamt;
    assign op2     = is_op ? b_q : imm_q;
    assign shamt   = op2[SHW-1:0];
    assign sra_res = $signed(a_q) >>> shamt;

    always_comb begin
        alu = '0;
        unique case (funct3)
            3'b000: alu = (is_op && ir[30]) ? a_q - op2 : a_q + op2;
            3'b001: alu = a_q << shamt;
            3'b010: alu = {{(WORDSIZE-1){1'b0}}, $signed(a_q) < $signed(op2)};
            3'b011: alu = {{(WORDSIZE-1){1'b0}}, a_q < op2};
            3'b100: alu = a_q ^ op2;
            3'b101: alu = ir[30] ? sra_res : a_q >> shamt;
            3'b110: alu = a_q | op2;
            3'b111: alu = a_q & op2;
        endcase
    end

    logic taken;
    always_comb begin
        taken = 1'b0;
        unique case (funct3)
            3'b000: taken = a_q == b_q;
            3'b001: taken = a_q != b_q;
            3'b100: taken = $signed(a_q) < $signed(b_q);
            3'b101: taken = $signed(a_q) >= $signed(b_q);
            3'b110: taken = a_q < b_q;
            3'b111: taken = a_q >= b_q;
            default: taken = 1'b0;
        endcase
    end

    logic [D_ADDR_BITS-1:0] ea_word;
    assign ea_word = D_ADDR_BITS'((a_q[EA_W-1:0] + imm_q[EA_W-1:0]) >> EA_LSB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (imem_ready) state_d = S_DECODE;
            S_DECODE: state_d = (is_sys || !legal) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (is_load || is_store) ? S_MEM :
                                is_branch ? S_FETCH : S_WB;
            S_MEM:    if (dmem_ready) state_d = is_load ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    // requests are gated by rst_n so an asserted reset drops them at once
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halted   = state_q == S_HALT;
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: imem_req = 1'b1;
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            ea_q      <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            unique case (state_q)
                S_FETCH: if (imem_ready) ir <= imem_rdata;
                S_DECODE: begin
                    a_q       <= rf[rs1];
                    b_q       <= rf[rs2];
                    imm_q     <= imm_d;
                    illegal_q <= !is_sys && !legal;
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        ea_q <= ea_word;
                    end else if (is_branch) begin
                        pc_q <= taken ? pc_q + imm_q : pc_q + FOUR;
                    end else if (is_jal) begin
                        res_q <= pc_q + FOUR;
                        pc_q  <= pc_q + imm_q;
                    end else begin
                        res_q <= alu;
                    end
                end
                S_MEM: if (dmem_ready) begin
                    if (is_load) res_q <= dmem_rdata;
                    else         pc_q  <= pc_q + FOUR;
                end
                S_WB: begin
                    if (rd != 5'd0) rf[rd] <= res_q;
                    if (!is_jal)    pc_q   <= pc_q + FOUR;
                end
                default: ;
            endcase
        end
    end

    assign pc         = pc_q;
    assign illegal    = illegal_q;
    assign imem_addr  = pc_q[I_ADDR_BITS+1:2];
    assign dmem_addr  = ea_q;
    assign dmem_wdata = b_q;

`ifdef PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else if (state_q != S_HALT) begin
            cycle_count <= cycle_count + 1'b1;
            if (state_q != S_FETCH && state_d == S_FETCH)
                instret_count <= instret_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed programs plus random ALU/LD programs checked
// against an instruction-level reference model, with wait-state memories.
module tb_multicycle_datapath;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req, imem_ready;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [5:0]  dmem_addr;
    logic [63:0] dmem_wdata, dmem_rdata, pc;
    logic        halted, illegal;
`ifdef PERF_COUNTERS_EN
    logic [63:0] cycle_count, instret_count;
`endif

    multicycle_datapath dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .pc(pc), .halted(halted),
        .illegal(illegal)
`ifdef PERF_COUNTERS_EN
        , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic [31:0] imem [64];
    logic [63:0] dmem [64];
    logic [63:0] mreg [8];
    int iwait = 0, dwait = 0, icnt, dcnt;
    int checks = 0, errors = 0;

    int f_addr [$];
    logic [63:0] f_pc [$];
    int dtx_len [$], dtx_addr [$], dtx_we [$];
    int dcur = 0, dunstable = 0;
    logic [5:0] dprev_addr;
    logic dprev_we;

    int f3_tab [19] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3, 0, 7, 6, 4, 2, 3, 1, 5, 5};
    int f7_tab [10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};

    assign imem_ready = imem_req && (icnt >= iwait);
    assign imem_rdata = imem[imem_addr];
    assign dmem_ready = dmem_req && (dcnt >= dwait);
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n && imem_req && imem_ready) begin
            f_addr.push_back(int'(imem_addr));
            f_pc.push_back(pc);
        end
        if (rst_n && dmem_req) begin
            if (dcur > 0 && (dmem_addr !== dprev_addr || dmem_we !== dprev_we))
                dunstable = dunstable + 1;
            dprev_addr = dmem_addr;
            dprev_we   = dmem_we;
            dcur = dcur + 1;
            if (dmem_ready) begin
                dtx_len.push_back(dcur);
                dtx_addr.push_back(int'(dmem_addr));
                dtx_we.push_back(int'(dmem_we));
                dcur = 0;
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            end
        end
    end

    function automatic logic [31:0] enc_r(input int f7, rs2, rs1, f3, rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, rs1, f3, rd, op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input int off, rs2, rs1, f3);
        return {off[11:5], rs2[4:0], rs1[4:0], f3[2:0], off[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int off, rs2, rs1, f3);
        return {off[12], off[10:5], rs2[4:0], rs1[4:0], f3[2:0],
                off[4:1], off[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input int off, rd);
        return {off[20], off[10:1], off[11], off[19:12], rd[4:0], 7'b1101111};
    endfunction

    // Instruction semantics by mnemonic: 0..9 register forms, 10..18 immediate forms
    function automatic logic [63:0] ref_alu(input int kind, input logic [63:0] x, y);
        logic signed [63:0] sx;
        sx = x;
        case (kind)
            0, 10:   return x + y;
            1:       return x - y;
            2, 11:   return x & y;
            3, 12:   return x | y;
            4, 13:   return x ^ y;
            5, 16:   return x << y[5:0];
            6, 17:   return x >> y[5:0];
            7, 18:   return sx >>> y[5:0];
            8, 14:   return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            9, 15:   return (x < y) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    function automatic int qget(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 64'h0;
        end
    endtask

    task automatic run(input int budget, output int cyc);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        f_addr.delete();
        f_pc.delete();
        dtx_len.delete();
        dtx_addr.delete();
        dtx_we.delete();
        dcur = 0;
        dunstable = 0;
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            cyc++;
            #1;
            if (halted) break;
        end
        chk("halt_reached", 64'(halted), 64'd1);
    endtask

    task automatic rand_prog(input int it);
        int kind, rd, r1, r2, imm, sh, j, exp_cyc, cyc;
        logic [63:0] x, y, r;
        clear_mem();
        iwait = $urandom_range(0, 2);
        dwait = $urandom_range(0, 2);
        for (int i = 0; i < 8; i++) mreg[i] = 64'd0;
        for (int i = 8; i < 16; i++) dmem[i] = {$urandom, $urandom};
        exp_cyc = 0;
        for (int k = 0; k < 20; k++) begin
            kind = $urandom_range(0, 19);
            rd   = $urandom_range(0, 7);
            r1   = $urandom_range(0, 7);
            r2   = $urandom_range(0, 7);
            x    = mreg[r1];
            if (kind == 19) begin
                j = $urandom_range(0, 7);
                imem[k] = enc_i(8 * (8 + j), 0, 3, rd, 'h03);
                r = dmem[8+j];
                exp_cyc += 5 + iwait + dwait;
            end else begin
                if (kind < 10) begin
                    y = mreg[r2];
                    imem[k] = enc_r(f7_tab[kind], r2, r1, f3_tab[kind], rd);
                end else if (kind >= 16) begin
                    sh  = $urandom_range(0, 63);
                    imm = sh | ((kind == 18) ? 'h400 : 0);
                    y   = 64'(sh);
                    imem[k] = enc_i(imm, r1, f3_tab[kind], rd, 'h13);
                end else begin
                    imm = $urandom_range(0, 4095);
                    y   = {{52{imm[11]}}, imm[11:0]};
                    imem[k] = enc_i(imm, r1, f3_tab[kind], rd, 'h13);
                end
                r = ref_alu(kind, x, y);
                exp_cyc += 4 + iwait;
            end
            if (rd != 0) mreg[rd] = r;
        end
        for (int i = 1; i < 8; i++) begin
            imem[19+i] = enc_s(8 * i, i, 0, 3);
            exp_cyc += 4 + iwait + dwait;
        end
        imem[27] = ECALL;
        exp_cyc += 2 + iwait;
        run(3000, cyc);
        chk($sformatf("rand%0d_cycles", it), 64'(cyc), 64'(exp_cyc));
        chk($sformatf("rand%0d_illegal", it), 64'(illegal), 64'd0);
        chk($sformatf("rand%0d_pc", it), pc, 64'd108);
        for (int i = 1; i < 8; i++)
            chk($sformatf("rand%0d_x%0d", it, i), dmem[i], mreg[i]);
    endtask

    initial begin
        int cyc;
        clear_mem();
        #2 rst_n = 1'b0;
        #2;
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_dmem_we", 64'(dmem_we), 64'd0);
        chk("rst_dmem_wdata", dmem_wdata, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_pc", pc, 64'd0);

        imem[0] = enc_i(5, 0, 0, 1, 'h13);
        imem[1] = enc_i(-3, 0, 0, 2, 'h13);
        imem[2] = enc_r(0, 2, 1, 0, 3);
        imem[3] = ECALL;
        run(200, cyc);
        chk("p1_cycles", 64'(cyc), 64'd14);
        chk("p1_illegal", 64'(illegal), 64'd0);
        chk("p1_pc", pc, 64'd12);
`ifdef PERF_COUNTERS_EN
        chk("p1_instret", instret_count, 64'd3);
        chk("p1_cycle_count", cycle_count, 64'd14);
`endif

        dwait = 3;
        imem[3] = enc_s(8, 3, 0, 3);
        imem[4] = enc_i(8, 0, 3, 4, 'h03);
        imem[5] = enc_s(16, 4, 0, 3);
        imem[6] = ECALL;
        run(300, cyc);
        chk("p2_x3", dmem[1], 64'd2);
        chk("p2_x4", dmem[2], 64'd2);
        chk("p2_ntx", 64'(dtx_len.size()), 64'd3);
        chk("p2_sd_len", 64'(qget(dtx_len, 0)), 64'd4);
        chk("p2_sd_addr", 64'(qget(dtx_addr, 0)), 64'd1);
        chk("p2_sd_we", 64'(qget(dtx_we, 0)), 64'd1);
        chk("p2_ld_len", 64'(qget(dtx_len, 1)), 64'd4);
        chk("p2_ld_addr", 64'(qget(dtx_addr, 1)), 64'd1);
        chk("p2_ld_we", 64'(qget(dtx_we, 1)), 64'd0);
        chk("p2_stable", 64'(dunstable), 64'd0);
        dwait = 0;

        clear_mem();
        imem[0] = enc_b(8, 1, 1, 0);
        imem[2] = enc_b(8, 1, 1, 1);
        imem[3] = ECALL;
        run(200, cyc);
        chk("br_beq_next", 64'(qget(f_addr, 1)), 64'd2);
        chk("br_bne_next", 64'(qget(f_addr, 2)), 64'd3);
        chk("br_cycles", 64'(cyc), 64'd8);
        chk("br_illegal", 64'(illegal), 64'd0);
        chk("br_pc", pc, 64'd12);

        clear_mem();
        imem[0]  = enc_j(-4, 1);
        imem[63] = enc_j(8, 0);
        imem[1]  = enc_s(0, 1, 0, 3);
        imem[2]  = ECALL;
        run(200, cyc);
        chk("jal_wrap_pc", (f_pc.size() > 1) ? f_pc[1] : 64'd0,
            64'hFFFF_FFFF_FFFF_FFFC);
        chk("jal_wrap_addr", 64'(qget(f_addr, 1)), 64'd63);
        chk("jal_link", dmem[0], 64'd4);
        chk("jal_pc", pc, 64'd8);
        chk("jal_cycles", 64'(cyc), 64'd14);

        clear_mem();
        dmem[0] = 64'hDEAD;
        imem[0] = enc_i(7, 0, 0, 0, 'h13);
        imem[1] = enc_r(0, 0, 0, 0, 5);
        imem[2] = enc_s(0, 5, 0, 3);
        run(200, cyc);
        chk("x0_x5", dmem[0], 64'd0);
        chk("x0_illegal", 64'(illegal), 64'd1);
        chk("x0_cycles", 64'(cyc), 64'd14);
        repeat (5) @(posedge clk);
        #1;
        chk("halt_fetches", 64'(f_addr.size()), 64'd4);
        chk("halt_no_req", 64'(imem_req), 64'd0);
        chk("halt_stays", 64'(halted), 64'd1);

        clear_mem();
        imem[0] = enc_i(0, 0, 2, 1, 'h03);
        run(50, cyc);
        chk("lw_illegal", 64'(illegal), 64'd1);
        chk("lw_cycles", 64'(cyc), 64'd2);

        for (int it = 0; it < 3; it++) rand_prog(it);

        iwait = 1000;
        dwait = 0;
        clear_mem();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midf_req_on", 64'(imem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midf_req_drop", 64'(imem_req), 64'd0);
        chk("midf_pc", pc, 64'd0);
        #20;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised RV64I-subset datapath with its own sequencing FSM: fetch, decode, execute, memory, write-back.
- Replaces the single-step datapath and its external control unit.
- Owns the 32-entry register file and the ALU.
- Talks to instruction and data memories through req/ready handshakes, so memories may insert wait states.
- Sits between the processor top and the two memory blocks.

Parameters:
- WORDSIZE, 64, datapath/register width in bits (32 or 64).
- INSTRUCTION_SIZE, 32, instruction width in bits.
- I_ADDR_BITS, 6, instruction memory word-address width.
- D_ADDR_BITS, 6, data memory word-address width.
- RESET_PC, 0, byte address loaded into PC at reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  I_ADDR_BITS  instruction word address = pc[I_ADDR_BITS+1:2].
- imem_ready  input  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  input  INSTRUCTION_SIZE  fetched instruction.
- dmem_req  output  1  data access request.
- dmem_we  output  1  1 = store, 0 = load; valid while dmem_req.
- dmem_addr  output  D_ADDR_BITS  word address = ea[D_ADDR_BITS+2:3] (ea[D_ADDR_BITS+1:2] when WORDSIZE=32).
- dmem_wdata  output  WORDSIZE  store data.
- dmem_ready  input  1  access complete; dmem_rdata valid on loads.
- dmem_rdata  input  WORDSIZE  load data.
- pc  output  WORDSIZE  current PC.
- halted  output  1  core stopped.
- illegal  output  1  stop was caused by an unsupported opcode.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; FSM=FETCH.
  - All registers x1..x31=0; IR=0.
  - imem_req=0, dmem_req=0, dmem_we=0, dmem_wdata=0, halted=0, illegal=0.
- Reset mid-transaction drops any request immediately. The memory must tolerate an abandoned request.
- FSM states: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH:
  - imem_req=1; imem_addr held stable until imem_ready.
  - On imem_ready: IR<=imem_rdata, go to DECODE.
  - Each cycle with imem_ready=0 stays in FETCH; no timeout.
- DECODE:
  - Latch A=rf[rs1], B=rf[rs2], sign-extended immediate (I/S/B/J formats).
  - Opcode 1110011 (ECALL/EBREAK) -> HALT, illegal=0.
  - Unsupported opcode -> HALT, illegal=1.
- EXECUTE:
  - OP/OP-IMM: ALU result to WB.
  - LOAD/STORE: ea=A+imm, go to MEM.
  - BRANCH: pc<=taken ? pc+immB : pc+4, go to FETCH.
  - JAL: result=pc+4, pc<=pc+immJ, go to WB.
- MEM:
  - dmem_req=1 with dmem_we/dmem_addr/dmem_wdata stable until dmem_ready.
  - Load -> WB with result=dmem_rdata.
  - Store -> pc<=pc+4, go to FETCH.
- WB:
  - rf[rd]<=result unless rd=0.
  - pc<=pc+4 except JAL (PC already updated); go to FETCH.
- HALT: absorbing; halted=1; only reset exits.
- Supported instructions:
  - OP: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU.
  - OP-IMM: ADDI ANDI ORI XORI SLTI SLTIU SLLI SRLI SRAI.
  - LOAD/STORE: LD and SD only (funct3=011; LW/SW when WORDSIZE=32). Any other funct3 is illegal.
  - BRANCH: BEQ BNE BLT BGE BLTU BGEU.
  - JAL.
- Arithmetic and width rules:
  - All arithmetic is modulo 2^WORDSIZE; PC wraps silently.
  - Shift amount = low log2(WORDSIZE) bits.
  - SLT/SLTU produce 0 or 1.
  - x0 always reads 0 and writes to it are discarded.
  - Low ea/pc alignment bits are ignored; no misalignment trap.
- Latency with zero-wait memories:
  - ALU/JAL: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds exactly 1.
- imem_req and dmem_req are never asserted together.

Optional Feature:
- PERF_COUNTERS_EN defined:
  - Adds outputs cycle_count and instret_count, both WORDSIZE wide, reset to 0.
  - cycle_count increments every non-HALT cycle.
  - instret_count increments on every transition back to FETCH (instruction retired).
  - Both freeze in HALT.
- PERF_COUNTERS_EN undefined: neither port nor counter logic exists.

Test Plan:
- Program ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; ECALL, zero-wait memories -> x3=2, halted=1 after 4+4+4+2 cycles (ECALL: FETCH+DECODE), illegal=0, pc=12.
- SD x3,8(x0) then LD x4,8(x0) with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles each with dmem_addr=1, dmem_we=1 then 0; x4=2.
- BEQ x1,x1,+8 at pc=0 -> next imem_addr=2; BNE x1,x1,+8 -> next imem_addr=1.
- JAL x1,-4 at pc=0 -> x1=4, pc=2^WORDSIZE-4 (wrap).
- ADDI x0,x0,7 then ADD x5,x0,x0 -> x5=0; opcode 0000000 -> halted=1, illegal=1, no further imem_req.
- Assert rst_n=0 mid-FETCH with imem_ready=0 -> imem_req=0 immediately, pc=RESET_PC. With PERF_COUNTERS_EN: after the first program, instret_count=3.
